// File: rtl/latch_bank_arbiter_if.sv
// Requester/latch-bank bundle for latch_bank_arbiter.
// master = client/bench side, slave = the arbiter.
interface latch_bank_arbiter_if #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int AW = 2
);
  logic          req0;
  logic [AW-1:0] addr0;
  logic [W-1:0]  d0;
  logic          req1;
  logic [AW-1:0] addr1;
  logic [W-1:0]  d1;
  logic [W-1:0]  ld;
  logic [N-1:0]  le;
  logic          ack0;
  logic          ack1;
  logic          gnt0;
  logic          gnt1;
  logic          busy;
  logic          err;

  modport master (
    output req0, addr0, d0, req1, addr1, d1,
    input  ld, le, ack0, ack1, gnt0, gnt1, busy, err
  );

  modport slave (
    input  req0, addr0, d0, req1, addr1, d1,
    output ld, le, ack0, ack1, gnt0, gnt1, busy, err
  );
endinterface

// File: rtl/latch_bank_arbiter.sv
// Round-robin write arbiter for a shared bank of level-sensitive latches.
// Each write runs setup -> enable -> hold so latch data is stable around the transparent window.
//
// state  | meaning
// IDLE   | waiting for a request; LD keeps its last value
// SETUP  | LD driven with captured data, LE low
// ENABLE | LE[captured addr] high for EN_CYCLES cycles
// HOLD   | LE low, LD held, ACK (and ERR if addr out of range)
module latch_bank_arbiter #(
  parameter int W         = 8,
  parameter int N         = 4,
  parameter int AW        = 2,
  parameter int EN_CYCLES = 1
) (
  input  logic                   c,
  input  logic                   r,
  latch_bank_arbiter_if.slave    bus
);
  localparam int EN_EFF = (EN_CYCLES < 1) ? 1 : EN_CYCLES;
  localparam int CW     = (EN_EFF > 1) ? $clog2(EN_EFF) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last, last_nxt;
  logic [AW-1:0] cap_addr, cap_addr_nxt;
  logic [W-1:0]  cap_data, cap_data_nxt;

  logic [W-1:0]  ld_q, ld_nxt;
  logic [N-1:0]  le_q, le_nxt;
  logic          ack0_q, ack0_nxt;
  logic          ack1_q, ack1_nxt;
  logic          gnt0_q, gnt0_nxt;
  logic          gnt1_q, gnt1_nxt;
  logic          busy_q, busy_nxt;
  logic          err_q, err_nxt;

  always_ff @(posedge c) begin
    if (r) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      cap_addr <= '0;
      cap_data <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last     <= last_nxt;
      cap_addr <= cap_addr_nxt;
      cap_data <= cap_data_nxt;
    end
  end

  // last doubles as the owner of the current slot: it is set to the winner at grant.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_nxt     = last;
    cap_addr_nxt = cap_addr;
    cap_data_nxt = cap_data;
    case (state)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || last)) begin
          last_nxt     = 1'b0;
          cap_addr_nxt = bus.addr0;
          cap_data_nxt = bus.d0;
          state_nxt    = SETUP;
        end else if (bus.req1) begin
          last_nxt     = 1'b1;
          cap_addr_nxt = bus.addr1;
          cap_data_nxt = bus.d1;
          state_nxt    = SETUP;
        end
      end
      SETUP: begin
        cnt_nxt   = CW'(EN_EFF - 1);
        state_nxt = ENABLE;
      end
      ENABLE: begin
        if (cnt == '0) state_nxt = HOLD;
        else           cnt_nxt   = cnt - 1'b1;
      end
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so LE has no input-to-output path.
  always_comb begin
    ld_nxt   = ld_q;
    le_nxt   = '0;
    ack0_nxt = 1'b0;
    ack1_nxt = 1'b0;
    gnt0_nxt = 1'b0;
    gnt1_nxt = 1'b0;
    busy_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (state_nxt != IDLE) begin
      ld_nxt   = cap_data_nxt;
      busy_nxt = 1'b1;
      gnt0_nxt = !last_nxt;
      gnt1_nxt = last_nxt;
    end
    if (state_nxt == ENABLE) begin
      for (int i = 0; i < N; i++) begin
        if (cap_addr_nxt == AW'(i)) le_nxt[i] = 1'b1;
      end
    end
    if (state_nxt == HOLD) begin
      ack0_nxt = !last_nxt;
      ack1_nxt = last_nxt;
      err_nxt  = (int'(cap_addr_nxt) >= N);
    end
  end

  always_ff @(posedge c) begin
    if (r) begin
      ld_q   <= '0;
      le_q   <= '0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ld_q   <= ld_nxt;
      le_q   <= le_nxt;
      ack0_q <= ack0_nxt;
      ack1_q <= ack1_nxt;
      gnt0_q <= gnt0_nxt;
      gnt1_q <= gnt1_nxt;
      busy_q <= busy_nxt;
      err_q  <= err_nxt;
    end
  end

  assign bus.ld   = ld_q;
  assign bus.le   = le_q;
  assign bus.ack0 = ack0_q;
  assign bus.ack1 = ack1_q;
  assign bus.gnt0 = gnt0_q;
  assign bus.gnt1 = gnt1_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Bench for latch_bank_arbiter: two configurations (N=4/EN=1 and N=3/EN=3)
// driven with directed then random requests, compared each cycle to a slot-position model.
module tb_latch_bank_arbiter;
  localparam int NCYC = 4000;

  logic c = 1'b0;
  logic r;
  always #5 c = ~c;

  latch_bank_arbiter_if #(.W(8), .N(4), .AW(2)) ifa ();
  latch_bank_arbiter_if #(.W(8), .N(3), .AW(2)) ifb ();

  latch_bank_arbiter #(.W(8), .N(4), .AW(2), .EN_CYCLES(1)) dut_a (.c(c), .r(r), .bus(ifa));
  latch_bank_arbiter #(.W(8), .N(3), .AW(2), .EN_CYCLES(3)) dut_b (.c(c), .r(r), .bus(ifb));

  logic       req0_s[2], req1_s[2];
  logic [1:0] a0_s[2], a1_s[2];
  logic [7:0] d0_s[2], d1_s[2];

  assign ifa.req0 = req0_s[0]; assign ifa.addr0 = a0_s[0]; assign ifa.d0 = d0_s[0];
  assign ifa.req1 = req1_s[0]; assign ifa.addr1 = a1_s[0]; assign ifa.d1 = d1_s[0];
  assign ifb.req0 = req0_s[1]; assign ifb.addr0 = a0_s[1]; assign ifb.d0 = d0_s[1];
  assign ifb.req1 = req1_s[1]; assign ifb.addr1 = a1_s[1]; assign ifb.d1 = d1_s[1];

  logic [7:0] o_ld[2];
  logic [3:0] o_le[2];
  logic       o_ack0[2], o_ack1[2], o_gnt0[2], o_gnt1[2], o_busy[2], o_err[2];

  assign o_ld[0] = ifa.ld;  assign o_le[0] = ifa.le;          assign o_ack0[0] = ifa.ack0;
  assign o_ack1[0] = ifa.ack1; assign o_gnt0[0] = ifa.gnt0;   assign o_gnt1[0] = ifa.gnt1;
  assign o_busy[0] = ifa.busy; assign o_err[0] = ifa.err;
  assign o_ld[1] = ifb.ld;  assign o_le[1] = {1'b0, ifb.le};  assign o_ack0[1] = ifb.ack0;
  assign o_ack1[1] = ifb.ack1; assign o_gnt0[1] = ifb.gnt0;   assign o_gnt1[1] = ifb.gnt1;
  assign o_busy[1] = ifb.busy; assign o_err[1] = ifb.err;

  // Model: pos = cycles since grant (0 idle, 1 setup, 2..E+1 enable, E+2 hold).
  int n_m[2] = '{4, 3};
  int e_m[2] = '{1, 3};
  int pos[2], owner[2], prev[2], caddr[2], cdata[2], ld_m[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int i);
    int winner;
    if (r) begin
      pos[i]  = 0;
      prev[i] = 1;
      ld_m[i] = 0;
      return;
    end
    if (pos[i] == 0) begin
      winner = -1;
      if (req0_s[i] && req1_s[i]) winner = 1 - prev[i];
      else if (req0_s[i])         winner = 0;
      else if (req1_s[i])         winner = 1;
      if (winner >= 0) begin
        owner[i] = winner;
        prev[i]  = winner;
        caddr[i] = (winner == 0) ? int'(a0_s[i]) : int'(a1_s[i]);
        cdata[i] = (winner == 0) ? int'(d0_s[i]) : int'(d1_s[i]);
        pos[i]   = 1;
      end
    end else if (pos[i] == e_m[i] + 2) begin
      pos[i] = 0;
    end else begin
      pos[i]++;
    end
    if (pos[i] != 0) ld_m[i] = cdata[i];
  endtask

  task automatic check_outputs(input int i, input int cyc);
    int  le_e;
    bit  act, hold;
    act  = (pos[i] != 0);
    hold = (pos[i] == e_m[i] + 2);
    le_e = (pos[i] >= 2 && pos[i] <= e_m[i] + 1 && caddr[i] < n_m[i]) ? (1 << caddr[i]) : 0;
    chk($sformatf("ld[%0d]@%0d", i, cyc),   32'(o_ld[i]),   32'(ld_m[i]));
    chk($sformatf("le[%0d]@%0d", i, cyc),   32'(o_le[i]),   32'(le_e));
    chk($sformatf("busy[%0d]@%0d", i, cyc), 32'(o_busy[i]), 32'(act));
    chk($sformatf("gnt0[%0d]@%0d", i, cyc), 32'(o_gnt0[i]), 32'(act && owner[i] == 0));
    chk($sformatf("gnt1[%0d]@%0d", i, cyc), 32'(o_gnt1[i]), 32'(act && owner[i] == 1));
    chk($sformatf("ack0[%0d]@%0d", i, cyc), 32'(o_ack0[i]), 32'(hold && owner[i] == 0));
    chk($sformatf("ack1[%0d]@%0d", i, cyc), 32'(o_ack1[i]), 32'(hold && owner[i] == 1));
    chk($sformatf("err[%0d]@%0d", i, cyc),  32'(o_err[i]),  32'(hold && caddr[i] >= n_m[i]));
  endtask

  initial begin
    r = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req0_s[i] = 1'b0; req1_s[i] = 1'b0;
      a0_s[i] = '0; a1_s[i] = '0; d0_s[i] = '0; d1_s[i] = '0;
      pos[i] = 0; owner[i] = 0; prev[i] = 1; caddr[i] = 0; cdata[i] = 0; ld_m[i] = 0;
      model_step(i);
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge c);
      for (int i = 0; i < 2; i++) check_outputs(i, cyc);

      if (cyc < 2) begin
        r = 1'b1;
      end else if (cyc < 40) begin
        // Both requesters held, each dropping for one cycle on its own ACK.
        r = (cyc == 30);
        for (int i = 0; i < 2; i++) begin
          a0_s[i] = 2'd0; d0_s[i] = 8'h11;
          a1_s[i] = 2'd3; d1_s[i] = 8'h22;
          req0_s[i] = !o_ack0[i];
          req1_s[i] = !o_ack1[i];
        end
      end else begin
        r = ($urandom_range(0, 99) == 0);
        for (int i = 0; i < 2; i++) begin
          a0_s[i] = 2'($urandom_range(0, 3));
          a1_s[i] = 2'($urandom_range(0, 3));
          d0_s[i] = 8'($urandom);
          d1_s[i] = 8'($urandom);
          if (o_ack0[i])    req0_s[i] = 1'b0;
          else if (!req0_s[i]) req0_s[i] = ($urandom_range(0, 2) == 0);
          else if ($urandom_range(0, 15) == 0) req0_s[i] = 1'b0;
          if (o_ack1[i])    req1_s[i] = 1'b0;
          else if (!req1_s[i]) req1_s[i] = ($urandom_range(0, 2) == 0);
          else if ($urandom_range(0, 15) == 0) req1_s[i] = 1'b0;
        end
      end

      for (int i = 0; i < 2; i++) model_step(i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/latch_bank_arbiter.md
Name: latch_bank_arbiter

Overview:
- Write controller and arbiter that shares one bank of N level-sensitive D latches, each W bits wide, between two requesters.
- Owns the latch enables and the shared data bus.
- Sequences every write as setup → enable → hold, so latch data is stable around the whole transparent window.
- Grants the two requesters round-robin and returns a one-cycle acknowledge per completed write.
- Sits between client logic and the latch bank; clients never drive latch enables directly.

Parameters:
W, 8, data width of each latch and of LD.
N, 4, number of latches in the bank (1..2**AW).
AW, 2, address width of ADDR0/ADDR1.
EN_CYCLES, 1, clock cycles LE stays high per write; 0 is treated as 1.

Ports:
C  input  1  clock, rising-edge.
R  input  1  synchronous active-high reset.
REQ0  input  1  requester 0 write request (level, held until ACK0).
ADDR0  input  AW  requester 0 target latch index.
D0  input  W  requester 0 write data.
REQ1  input  1  requester 1 write request (level, held until ACK1).
ADDR1  input  AW  requester 1 target latch index.
D1  input  W  requester 1 write data.
LD  output  W  data bus to all latch D inputs.
LE  output  N  one-hot latch enables (latch C inputs).
ACK0  output  1  one-cycle pulse: requester 0 write complete.
ACK1  output  1  one-cycle pulse: requester 1 write complete.
GNT0  output  1  requester 0 owns the bank (SETUP..HOLD).
GNT1  output  1  requester 1 owns the bank (SETUP..HOLD).
BUSY  output  1  FSM not in IDLE.
ERR  output  1  one-cycle pulse with ACK when granted address >= N.

Behaviour:
- One clock C; reset R is synchronous and active-high.
- All outputs are registered. No combinational path from inputs to LE, so LE is glitch-free.
- Reset (sampled at rising edge of C):
  - LD=0, LE=0, ACK0=ACK1=0, GNT0=GNT1=0, BUSY=0, ERR=0.
  - FSM=IDLE, round-robin pointer LAST=1 (requester 0 wins the first tie), enable counter=0.
- FSM states: IDLE, SETUP, ENABLE, HOLD.
- IDLE:
  - If only REQx=1, grant x.
  - If both are high, grant the requester that is not LAST.
  - On grant: capture ADDRx/Dx into internal regs, set LAST=x, go to SETUP.
  - Changes on ADDR/D after the grant edge are ignored.
- SETUP (1 cycle):
  - LD=captured data, LE=0, GNTx=1, BUSY=1.
- ENABLE (EN_CYCLES cycles):
  - LE[captured addr]=1, all other LE bits=0.
  - LD held.
  - Down-counter runs; exit to HOLD when it expires.
- HOLD (1 cycle):
  - LE=0, LD still held, ACKx=1.
  - ERR=1 if captured addr >= N.
  - Next state IDLE.
- Out-of-range address: no LE bit ever asserts; the full sequence and ACK still occur.
- Latency: REQ sampled high at edge k in IDLE →
  - SETUP in cycle k+1,
  - ENABLE in k+2 .. k+1+EN_CYCLES,
  - HOLD/ACK in k+2+EN_CYCLES,
  - IDLE in k+3+EN_CYCLES.
  - With EN_CYCLES=1 this is a 4-cycle slot and 25% max bank duty.
- Idle gap: at least one IDLE cycle between consecutive grants.
- Request level after ACK: REQx still high at the IDLE edge after ACKx counts as a new request. Requesters must drop REQ on the edge they sample ACK.
- REQ dropped before ACK: the transfer is not aborted and ACK is still issued.
- LD holds its last value in IDLE (no bus toggling).
- GNT0 and GNT1 are never both high. ACK0 and ACK1 are never both high.
- Reset mid-operation:
  - At that edge, LE drops to 0 and the FSM goes to IDLE.
  - No ACK or ERR is issued for the aborted transfer.
  - LAST returns to 1.

Test Plan:
1. Reset, then REQ0=1, ADDR0=2, D0=8'hA5 at edge 1:
   - LD=A5 from cycle 2; LE=4'b0100 only in cycle 3; ACK0 pulse in cycle 4; BUSY high cycles 2-4; GNT0 high cycles 2-4.
2. REQ0 and REQ1 asserted together from reset (D0=11, ADDR0=0; D1=22, ADDR1=3), both held until ACK:
   - Requester 0 is served first (LE=0001, ACK0).
   - Then, after one IDLE cycle, requester 1 (LE=1000, ACK1).
   - GNT0 and GNT1 never overlap.
3. Both requesters held continuously for 4 slots:
   - Grant order 0,1,0,1; exactly one ACK per slot; no LE overlap between slots.
4. N=3, REQ1 with ADDR1=3, D1=8'hFF:
   - LE stays 000 throughout; ACK1 and ERR pulse together in HOLD.
5. EN_CYCLES=3, REQ0 ADDR0=1:
   - LE=0010 for exactly 3 cycles.
   - LD stable from SETUP through HOLD.
   - ACK0 in cycle k+5.
6. R asserted during the ENABLE cycle of a write:
   - At the next edge LE=0, BUSY=0, GNT=0, and no ACK.
   - A subsequent simultaneous REQ0/REQ1 grants requester 0 first.
